// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, opcodes and instruction field layout for the ALU operand issuer
package alu_issue_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_NREG   = 8;
    localparam int ALU_AW     = $clog2(ALU_NREG);
    localparam int ALU_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 13;
    localparam int RD_MSB     = 12;
    localparam int RD_LSB     = 10;
    localparam int RS1_MSB    = 9;
    localparam int RS1_LSB    = 7;
    localparam int RS2_MSB    = 6;
    localparam int RS2_LSB    = 4;
    localparam int IMM_EN_BIT = 3;
    localparam int RSVD_MSB   = 2;
    localparam int RSVD_LSB   = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       imm_en;
        logic [2:0] rsvd;
    } instr_t;

    // Field extraction by named bit positions so the layout lives in one place
    function automatic instr_t decode_instr(input logic [15:0] raw);
        instr_t d;
        d.op     = raw[OP_MSB:OP_LSB];
        d.rd     = raw[RD_MSB:RD_LSB];
        d.rs1    = raw[RS1_MSB:RS1_LSB];
        d.rs2    = raw[RS2_MSB:RS2_LSB];
        d.imm_en = raw[IMM_EN_BIT];
        d.rsvd   = raw[RSVD_MSB:RSVD_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - operand register file with two read ports, debug read and r0 tied to zero
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREG   = ALU_NREG,
    parameter int AW     = ALU_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    input  logic [AW-1:0]     rs2_addr_i,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREG];

    // Single write port; entry 0 is cleared on reset and never written, so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = regs_q[rs1_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - decodes instructions, issues registered operands to the ALU and writes results back
module alu_operand_issue
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREG   = ALU_NREG,
    parameter int CNT_W  = ALU_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [15:0]                instr,
    input  logic [DATA_W-1:0]          instr_imm,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [2:0]                 alu_op,
    input  logic [DATA_W-1:0]          alu_out,
    output logic                       res_valid,
    output logic [$clog2(NREG)-1:0]    res_rd,
    output logic [DATA_W-1:0]          res_data,
    output logic [CNT_W-1:0]           retire_cnt,
    input  logic [$clog2(NREG)-1:0]    dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    localparam int AW = $clog2(NREG);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_b_q, res_data_q;
    logic [2:0]        alu_op_q;
    logic [AW-1:0]     rd_q, res_rd_q;
    logic              res_valid_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    instr_t            dec;
    logic              accept;
    logic              fwd_rs1, fwd_rs2;
    logic [DATA_W-1:0] rf_rs1_data, rf_rs2_data;
    logic [DATA_W-1:0] opa_d, opb_d;
    logic              rf_we;
    logic              unused_rsvd;

    assign dec         = decode_instr(instr);
    assign unused_rsvd = ^dec.rsvd;

    // Ready is forced low while reset is asserted even though the state already reads IDLE
    assign instr_ready = rst_n && ((state_q == IDLE) || (state_q == WB));
    assign accept      = instr_valid && instr_ready;

    // The result being written back this cycle is not yet in the array, so a WB-cycle accept
    // that names that register must take it from res_data; r0 never forwards
    assign fwd_rs1 = (state_q == WB) && (res_rd_q != '0) && (dec.rs1 == res_rd_q);
    assign fwd_rs2 = (state_q == WB) && (res_rd_q != '0) && (dec.rs2 == res_rd_q);

    // Operand selection: bypass over array read, immediate overrides rs2
    always_comb begin
        opa_d = fwd_rs1 ? res_data_q : rf_rs1_data;
        opb_d = rf_rs2_data;
        if (dec.imm_en) begin
            opb_d = instr_imm;
        end else if (fwd_rs2) begin
            opb_d = res_data_q;
        end
    end

    // Next-state: one EXEC cycle, one WB cycle, WB may overlap the next accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = WB;
            WB:      state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus all registered issue/write-back outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rd_q         <= '0;
            res_valid_q  <= 1'b0;
            res_rd_q     <= '0;
            res_data_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_op_q <= dec.op;
                rd_q     <= dec.rd;
                alu_a_q  <= opa_d;
                alu_b_q  <= opb_d;
            end
            if (state_q == EXEC) begin
                res_data_q <= alu_out;
                res_rd_q   <= rd_q;
            end
            res_valid_q <= (state_q == EXEC);
            if (state_q == WB) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rf_we = (state_q == WB);

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr_i (dec.rs1),
        .rs1_data_o (rf_rs1_data),
        .rs2_addr_i (dec.rs2),
        .rs2_data_o (rf_rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .waddr_i    (res_rd_q),
        .wdata_i    (res_data_q)
    );

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign res_valid  = res_valid_q;
    assign res_rd     = res_rd_q;
    assign res_data   = res_data_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - self-checking bench for alu_operand_issue with an 8-bit ALU and architectural model
module tb_alu_operand_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_imm;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [7:0]  res_data;
    logic [15:0] retire_cnt;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] mr [8];
    logic [2:0] q_rd [$];
    logic [7:0] q_data [$];
    int         exp_retire = 0;

    always #5 clk = ~clk;

    alu_operand_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_rd      (res_rd),
        .res_data    (res_data),
        .retire_cnt  (retire_cnt),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[2:0];
            OP_SHR:  return a >> b[2:0];
            OP_PASSB: return b;
            default: return 8'h00;
        endcase
    endfunction

    // Team ALU stand-in: purely combinational on the issued operands
    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_exec(input logic [15:0] ins, input logic [7:0] imm);
        logic [2:0] op, rd, rs1, rs2;
        logic [7:0] a, b, r;
        op  = ins[15:13];
        rd  = ins[12:10];
        rs1 = ins[9:7];
        rs2 = ins[6:4];
        a   = mr[rs1];
        b   = ins[3] ? imm : mr[rs2];
        r   = alu_fn(op, a, b);
        if (rd != 3'd0) mr[rd] = r;
        q_rd.push_back(rd);
        q_data.push_back(r);
        exp_retire++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 8'h00;
        q_rd.delete();
        q_data.delete();
        exp_retire = 0;
    endtask

    task automatic send(input logic [15:0] ins, input logic [7:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        instr_imm   = imm;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("send_timeout", instr_ready, 1);
            instr_valid = 1'b0;
            return;
        end
        model_exec(ins, imm);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        instr_imm   = 8'($urandom);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        @(negedge clk);
        while ((q_rd.size() != 0 || !instr_ready || res_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("quiet_timeout", {31'd0, instr_ready && !res_valid}, 1);
    endtask

    // Scoreboard: every write-back must match the next expected retirement in order
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1) begin
            if (q_rd.size() == 0) begin
                chk("res_valid_unexpected", res_valid, 0);
            end else begin
                chk("wb_res_rd", res_rd, q_rd.pop_front());
                chk("wb_res_data", res_data, q_data.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        instr_imm   = 8'h00;
        dbg_addr    = 3'd0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_rd", res_rd, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_retire", retire_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", instr_ready, 1);

        // 1: ADD r1 <= r0 + imm 5, latency and debug visibility
        dbg_addr = 3'd1;
        send(16'h0408, 8'h05);
        @(negedge clk);
        chk("t1_exec_res_valid", res_valid, 0);
        chk("t1_alu_a", alu_a, 8'h00);
        chk("t1_alu_b", alu_b, 8'h05);
        chk("t1_alu_op", alu_op, 3'd0);
        @(negedge clk);
        chk("t1_wb_res_valid", res_valid, 1);
        chk("t1_res_rd", res_rd, 3'd1);
        chk("t1_res_data", res_data, 8'h05);
        chk("t1_dbg_in_wb", dbg_data, 8'h00);
        @(negedge clk);
        chk("t1_after_res_valid", res_valid, 0);
        chk("t1_dbg_r1", dbg_data, 8'h05);
        chk("t1_retire", retire_cnt, 16'd1);

        // 2: back-to-back with bypass of r2 into the WB-cycle accept
        send(16'h0808, 8'hFF);
        send(16'h0D20, 8'h00);
        @(negedge clk);
        chk("t2_bypass_a", alu_a, 8'hFF);
        chk("t2_bypass_b", alu_b, 8'hFF);
        @(negedge clk);
        chk("t2_res_rd", res_rd, 3'd3);
        chk("t2_res_data", res_data, 8'hFE);
        wait_quiet();
        chk("t2_retire", retire_cnt, 16'(exp_retire));
        dbg_addr = 3'd3;
        #1;
        chk("t2_dbg_r3", dbg_data, 8'hFE);

        // 3: write to r0 is reported but discarded
        send(16'h0008, 8'hAA);
        @(negedge clk);
        @(negedge clk);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_res_rd", res_rd, 3'd0);
        chk("t3_res_data", res_data, 8'hAA);
        wait_quiet();
        dbg_addr = 3'd0;
        #1;
        chk("t3_dbg_r0", dbg_data, 8'h00);
        chk("t3_retire", retire_cnt, 16'd4);

        // 4: valid held for six cycles, r5 <= r5 + 1 each accept
        acc = 0;
        instr_valid = 1'b1;
        instr       = 16'h1688;
        instr_imm   = 8'h01;
        for (int i = 0; i < 6; i++) begin
            chk("t4_ready_pattern", instr_ready, (i % 2 == 0) ? 1 : 0);
            if (instr_ready) begin
                acc++;
                model_exec(16'h1688, 8'h01);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("t4_accepts", acc, 3);
        wait_quiet();
        dbg_addr = 3'd5;
        #1;
        chk("t4_dbg_r5", dbg_data, 8'h03);
        chk("t4_retire", retire_cnt, 16'd7);

        // 5: reset during EXEC of r4 <= imm 3C drops the instruction
        send(16'h1008, 8'h3C);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_ready", instr_ready, 0);
        chk("t5_alu_a", alu_a, 0);
        chk("t5_alu_b", alu_b, 0);
        chk("t5_alu_op", alu_op, 0);
        chk("t5_res_valid", res_valid, 0);
        chk("t5_res_rd", res_rd, 0);
        chk("t5_res_data", res_data, 0);
        chk("t5_retire", retire_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 3'd4;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_wb", res_valid, 0);
        end
        chk("t5_dbg_r4", dbg_data, 8'h00);
        dbg_addr = 3'd5;
        #1;
        chk("t5_dbg_r5", dbg_data, 8'h00);

        // 6: 500 random instructions with random gaps
        for (int k = 0; k < 500; k++) begin
            send(16'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_quiet();
        chk("t6_retire", retire_cnt, 16'd500);
        chk("t6_retire_model", retire_cnt, 16'(exp_retire));
        chk("t6_queue_drained", q_rd.size(), 0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk("t6_dbg_reg", dbg_data, mr[r]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
